psg_bus_arbiter: RTL and testbench
==================================

Name: psg_bus_arbiter

Overview:
- Shares the single PSG register bus (4-bit addr, 8-bit data, active-low wr_n, 8-bit dout) between NUM_REQ requesters, e.g. host CPU, tracker/playback engine and a debug port.
- Sits between the requesters and the PSG system's addr/data/wr_n/dout ports, in the same clock domain.
- Serialises writes and reads with a valid/ready handshake, round-robin arbitration, a programmable write-strobe width and a programmable inter-access gap.
- Returns read data to the requester that issued the read.

Parameters:
- NUM_REQ, 3, number of requesters; legal range 2..8.
- WR_PULSE, 2, clk cycles psg_wr_n is held low per write; must be at least 1.
- WR_GAP, 1, idle cycles after each access before the next grant; 0 is legal.
- READ_LAT, 2, clk cycles from psg_addr valid to psg_dout sampled; must be at least 1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*4  packed register addresses; requester i uses bits [4i+3:4i]
- req_data  in  NUM_REQ*8  packed write data; requester i uses bits [8i+7:8i]
- rsp_valid  out  NUM_REQ  one-cycle read-data-valid pulse to the issuing requester
- rsp_data  out  8  read data; valid only with rsp_valid
- psg_addr  out  4  to PSG addr
- psg_data  out  8  to PSG data
- psg_wr_n  out  1  to PSG wr_n, active low
- psg_dout  in  8  from PSG dout
- busy  out  1  high whenever state is not IDLE
- grant_id  out  $clog2(NUM_REQ)  index of the current or most recent grant

Behaviour:
- Reset values:
  - state = IDLE; psg_wr_n = 1.
  - psg_addr, psg_data, rsp_data, grant_id = 0.
  - req_ready, rsp_valid = 0; busy = 0.
  - round-robin pointer rr = 0.
- State machine, states IDLE, WRITE, READ, GAP.
- IDLE:
  - Search for the first i with req_valid[i] set, starting at rr and wrapping modulo NUM_REQ.
  - req_ready[i] is driven combinationally high only for that i, and only in IDLE.
  - Acceptance occurs when valid & ready in the same cycle.
  - On accept, register the following:
    - grant_id = i
    - psg_addr = req_addr[i]
    - psg_data = req_data[i] (writes only)
    - rr = (i+1) mod NUM_REQ
  - Next state is WRITE if req_we[i] is set, otherwise READ.
  - With no valid requests, state and rr are unchanged.
- WRITE:
  - psg_wr_n = 0 for exactly WR_PULSE cycles, starting the cycle after accept.
  - psg_addr and psg_data are stable throughout.
  - Then go to GAP, or to IDLE if WR_GAP = 0.
- READ:
  - psg_wr_n stays 1; psg_addr is held for READ_LAT cycles.
  - In the last READ cycle, register rsp_data = psg_dout.
  - rsp_valid[grant_id] pulses for exactly 1 cycle, the cycle after that capture.
  - Then go to GAP, or to IDLE if WR_GAP = 0.
- GAP: psg_wr_n = 1 for WR_GAP cycles, then IDLE.
- Latency and throughput:
  - Write occupancy is WR_PULSE+WR_GAP cycles after the accept cycle.
  - The read response arrives READ_LAT+1 cycles after accept.
  - Back-to-back throughput is 1 access per (1+WR_PULSE+WR_GAP) cycles.
- Requester rules:
  - A requester keeps valid, we, addr and data stable until accepted.
  - Dropping valid before ready is legal; that requester loses its slot and the arbiter re-searches each IDLE cycle.
- Fairness: with all requesters permanently valid, grants cycle 0,1,..,NUM_REQ-1,0,…
- Simultaneous events:
  - A new request arriving during WRITE, READ or GAP waits; ready stays 0.
  - rsp_valid and a new accept can never occur in the same cycle when WR_GAP ≥ 1.
  - With WR_GAP = 0, the rsp_valid cycle is an IDLE cycle and an accept in that cycle is allowed.
- Reset mid-access: psg_wr_n returns to 1 asynchronously. A truncated write is acceptable and no response is issued.
- Width rule: grant_id width is $clog2(NUM_REQ); the counter holds max(WR_PULSE,READ_LAT,WR_GAP) in $clog2(max+1) bits.

Optional Feature:
- Macro: PSG_BUS_ARB_PRIORITY_EN.
- When defined, requester 0 has fixed highest priority.
  - Whenever req_valid[0] is high in IDLE, it is granted.
  - The remaining requesters are round-robin among themselves, and rr skips 0.
- When undefined, all requesters are pure round-robin as above.

Decomposition:
- Package psg_bus_arb_pkg:
  - state enum typedef {IDLE, WRITE, READ, GAP}
  - PSG_ADDR_W = 4, PSG_DATA_W = 8
  - function rr_next(ptr, n)
- Sub-module psg_rr_picker: a purely combinational rotate-priority encoder (inputs: valid vector, rr; outputs: one-hot grant, index, any).
- The FSM, timers and datapath registers live in psg_bus_arbiter.

Test Plan:
- Reset, then req 1 writes addr 7, data 0x3E.
  - ready[1] rises in the same cycle.
  - psg_addr = 7 and psg_data = 0x3E, with psg_wr_n low for exactly 2 cycles.
  - busy then stays high for 1 GAP cycle.
- Req 2 reads addr 8 while the psg_dout model returns 0x1F.
  - rsp_valid[2] pulses once, 3 cycles after accept, with rsp_data = 0x1F.
  - No psg_wr_n activity occurs.
- All 3 requesters valid continuously with 6 writes: grant_id sequence is 0,1,2,0,1,2, with accepts spaced 4 cycles apart.
- Reset asserted during the 1st WRITE cycle: psg_wr_n = 1 immediately, all outputs return to reset values, no rsp_valid.
- Req 0 drops valid before it is granted while req 1 is valid: req 1 is granted and no write is issued for req 0.
- With PSG_BUS_ARB_PRIORITY_EN defined, req 0 and req 2 both valid repeatedly: req 0 is always granted first; req 2 is granted only when req 0 is low.

Source files
------------

// File: rtl/psg_bus_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : psg_bus_arb_pkg
//  Description : Shared types, widths and helpers for the PSG register-bus
//                arbiter (state encoding, PSG bus widths, round-robin step).
//  Revision    : 1.0 - initial release
// ============================================================================
package psg_bus_arb_pkg;

    localparam int PSG_ADDR_W = 4;
    localparam int PSG_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        GAP   = 2'd3
    } arb_state_t;

    // Advance a round-robin pointer by one, wrapping at n.
    function automatic int rr_next(input int ptr, input int n);
        if (ptr + 1 >= n) begin
            return 0;
        end
        return ptr + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/psg_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module      : psg_rr_picker
//  Description : Combinational rotate-priority encoder. Finds the first set
//                bit of 'valid' starting at index 'rr' and wrapping around.
//  Revision    : 1.0 - initial release
// ============================================================================
module psg_rr_picker #(
    parameter int N  = 3,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] rr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Walk the requesters from rr upward, wrapping, and keep the first hit.
    always_comb begin
        int j;
        j     = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(rr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!any && valid[j]) begin
                any      = 1'b1;
                idx      = IW'(j);
                grant[j] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/psg_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : psg_bus_arbiter
//  Description : Shares the PSG register bus between NUM_REQ requesters with
//                valid/ready handshakes, round-robin arbitration, a
//                programmable write-strobe width, read latency and inter-
//                access gap. Read data is returned to the issuing requester.
//                Optional: define PSG_BUS_ARB_PRIORITY_EN to give requester 0
//                fixed highest priority (others round-robin, rr skips 0).
//  Revision    : 1.0 - initial release
// ============================================================================
module psg_bus_arbiter
    import psg_bus_arb_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int WR_PULSE = 2,
    parameter int WR_GAP   = 1,
    parameter int READ_LAT = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*PSG_ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*PSG_DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [PSG_DATA_W-1:0]         rsp_data,
    output logic [PSG_ADDR_W-1:0]         psg_addr,
    output logic [PSG_DATA_W-1:0]         psg_data,
    output logic                          psg_wr_n,
    input  logic [PSG_DATA_W-1:0]         psg_dout,
    output logic                          busy,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

    localparam int IW      = $clog2(NUM_REQ);
    localparam int MAX_A   = (WR_PULSE > READ_LAT) ? WR_PULSE : READ_LAT;
    localparam int CNT_MAX = (MAX_A > WR_GAP) ? MAX_A : WR_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Counters load "cycles - 1" so that zero marks the last cycle of a phase.
    localparam logic [CNT_W-1:0] c_wr_load  = CNT_W'(WR_PULSE - 1);
    localparam logic [CNT_W-1:0] c_rd_load  = CNT_W'(READ_LAT - 1);
    localparam logic [CNT_W-1:0] c_gap_load = CNT_W'((WR_GAP > 0) ? (WR_GAP - 1) : 0);

    arb_state_t                r_state;
    arb_state_t                w_next_state;
    logic [CNT_W-1:0]          r_cnt;
    logic [IW-1:0]             r_rr;
    logic [IW-1:0]             r_grant_id;
    logic [PSG_ADDR_W-1:0]     r_addr;
    logic [PSG_DATA_W-1:0]     r_data;
    logic                      r_wr_n;
    logic [PSG_DATA_W-1:0]     r_rsp_data;
    logic [NUM_REQ-1:0]        r_rsp_valid;

    logic [NUM_REQ-1:0]        w_pick_valid;
    logic [NUM_REQ-1:0]        w_rr_grant;
    logic [IW-1:0]             w_rr_idx;
    logic                      w_rr_any;
    logic [NUM_REQ-1:0]        w_sel_onehot;
    logic [IW-1:0]             w_sel_idx;
    logic                      w_sel_any;
    logic                      w_accept;
    logic                      w_sel_we;
    logic [IW-1:0]             w_rr_upd;
    logic                      w_phase_last;

    logic [PSG_ADDR_W-1:0]     w_addr [NUM_REQ];
    logic [PSG_DATA_W-1:0]     w_data [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_addr[gi] = req_addr[gi*PSG_ADDR_W +: PSG_ADDR_W];
        assign w_data[gi] = req_data[gi*PSG_DATA_W +: PSG_DATA_W];
    end

`ifdef PSG_BUS_ARB_PRIORITY_EN
    // Requester 0 is served outside the rotation, so hide it from the picker.
    assign w_pick_valid = {req_valid[NUM_REQ-1:1], 1'b0};
`else
    assign w_pick_valid = req_valid;
`endif

    psg_rr_picker #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_picker (
        .valid (w_pick_valid),
        .rr    (r_rr),
        .grant (w_rr_grant),
        .idx   (w_rr_idx),
        .any   (w_rr_any)
    );

    // Final selection and the round-robin pointer value to store on accept.
    always_comb begin
        int nxt;
`ifdef PSG_BUS_ARB_PRIORITY_EN
        w_sel_any    = req_valid[0] | w_rr_any;
        w_sel_idx    = req_valid[0] ? '0 : w_rr_idx;
        w_sel_onehot = req_valid[0] ? NUM_REQ'(1) : w_rr_grant;
        nxt          = rr_next(int'(w_sel_idx), NUM_REQ);
        if (nxt == 0) begin
            nxt = 1;
        end
        // A priority grant of requester 0 leaves the rotation untouched.
        w_rr_upd     = (w_sel_idx == '0) ? r_rr : IW'(nxt);
`else
        w_sel_any    = w_rr_any;
        w_sel_idx    = w_rr_idx;
        w_sel_onehot = w_rr_grant;
        nxt          = rr_next(int'(w_sel_idx), NUM_REQ);
        w_rr_upd     = IW'(nxt);
`endif
    end

    assign req_ready    = (r_state == IDLE) ? w_sel_onehot : '0;
    assign w_accept     = |(req_valid & req_ready);
    assign w_sel_we     = req_we[w_sel_idx];
    assign w_phase_last = (r_cnt == '0);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: each access phase ends when its counter reaches zero.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = w_sel_we ? WRITE : READ;
                end
            end
            WRITE, READ: begin
                if (w_phase_last) begin
                    w_next_state = (WR_GAP == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (w_phase_last) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Phase timer shared by WRITE, READ and GAP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_cnt <= w_sel_we ? c_wr_load : c_rd_load;
                    end
                end
                WRITE, READ: begin
                    r_cnt <= w_phase_last ? c_gap_load : r_cnt - 1'b1;
                end
                default: begin
                    if (!w_phase_last) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
            endcase
        end
    end

    // Bus-side datapath, grant bookkeeping and read response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grant_id  <= '0;
            r_rr        <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_wr_n      <= 1'b1;
            r_rsp_data  <= '0;
            r_rsp_valid <= '0;
        end else begin
            r_rsp_valid <= '0;
            if (w_accept) begin
                r_grant_id <= w_sel_idx;
                r_addr     <= w_addr[w_sel_idx];
                r_rr       <= w_rr_upd;
                r_wr_n     <= ~w_sel_we;
                if (w_sel_we) begin
                    r_data <= w_data[w_sel_idx];
                end
            end
            if (r_state == WRITE && w_phase_last) begin
                r_wr_n <= 1'b1;
            end
            if (r_state == READ && w_phase_last) begin
                r_rsp_data              <= psg_dout;
                r_rsp_valid[r_grant_id] <= 1'b1;
            end
        end
    end

    assign psg_addr  = r_addr;
    assign psg_data  = r_data;
    assign psg_wr_n  = r_wr_n;
    assign rsp_data  = r_rsp_data;
    assign rsp_valid = r_rsp_valid;
    assign grant_id  = r_grant_id;
    assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_psg_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_psg_bus_arbiter
//  Description : Directed self-checking bench for psg_bus_arbiter (defaults
//                NUM_REQ=3, WR_PULSE=2, WR_GAP=1, READ_LAT=2). The priority
//                scenario is built when PSG_BUS_ARB_PRIORITY_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_psg_bus_arbiter;

    logic        clk;
    logic        reset;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [2:0]  req_we;
    logic [11:0] req_addr;
    logic [23:0] req_data;
    logic [2:0]  rsp_valid;
    logic [7:0]  rsp_data;
    logic [3:0]  psg_addr;
    logic [7:0]  psg_data;
    logic        psg_wr_n;
    logic [7:0]  psg_dout;
    logic        busy;
    logic [1:0]  grant_id;

    int n_vec = 0;
    int n_err = 0;

    psg_bus_arbiter #(
        .NUM_REQ  (3),
        .WR_PULSE (2),
        .WR_GAP   (1),
        .READ_LAT (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .psg_addr  (psg_addr),
        .psg_data  (psg_data),
        .psg_wr_n  (psg_wr_n),
        .psg_dout  (psg_dout),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    // PSG read model: register 8 reads back 0x1F, everything else 0xE0.
    assign psg_dout = (psg_addr == 4'd8) ? 8'h1F : 8'hE0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int onehot_idx(input logic [2:0] v);
        for (int i = 0; i < 3; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int last_cyc;
        int idx;
        logic rec;

        reset     = 1'b1;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_data  = '0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        #1;

        // ---- reset values ----
        check_eq("rst_wr_n",      32'(psg_wr_n),  32'd1);
        check_eq("rst_busy",      32'(busy),      32'd0);
        check_eq("rst_addr",      32'(psg_addr),  32'd0);
        check_eq("rst_data",      32'(psg_data),  32'd0);
        check_eq("rst_grant",     32'(grant_id),  32'd0);
        check_eq("rst_ready",     32'(req_ready), 32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rsp_data",  32'(rsp_data),  32'd0);
        tick();

        // ---- test 1: req 1 writes 0x3E to register 7 ----
        req_valid = 3'b010; req_we = 3'b010;
        req_addr[7:4] = 4'd7; req_data[15:8] = 8'h3E;
        #1;
        check_eq("t1_ready", 32'(req_ready), 32'b010);
        tick();
        req_valid = '0;
        check_eq("t1_w1_wr_n",  32'(psg_wr_n),  32'd0);
        check_eq("t1_w1_addr",  32'(psg_addr),  32'd7);
        check_eq("t1_w1_data",  32'(psg_data),  32'h3E);
        check_eq("t1_w1_grant", 32'(grant_id),  32'd1);
        check_eq("t1_w1_busy",  32'(busy),      32'd1);
        check_eq("t1_w1_ready", 32'(req_ready), 32'd0);
        tick();
        check_eq("t1_w2_wr_n",  32'(psg_wr_n),  32'd0);
        check_eq("t1_w2_addr",  32'(psg_addr),  32'd7);
        tick();
        check_eq("t1_gap_wr_n", 32'(psg_wr_n),  32'd1);
        check_eq("t1_gap_busy", 32'(busy),      32'd1);
        tick();
        check_eq("t1_idle_busy", 32'(busy),     32'd0);

        // ---- test 2: req 2 reads register 8 ----
        req_valid = 3'b100; req_we = 3'b000; req_addr[11:8] = 4'd8;
        #1;
        check_eq("t2_ready", 32'(req_ready), 32'b100);
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 1) begin
                req_valid = '0;
                check_eq("t2_addr", 32'(psg_addr), 32'd8);
            end
            check_eq("t2_rsp_valid", 32'(rsp_valid), (k == 3) ? 32'b100 : 32'd0);
            check_eq("t2_wr_n",      32'(psg_wr_n),  32'd1);
            if (k == 3) begin
                check_eq("t2_rsp_data", 32'(rsp_data), 32'h1F);
            end
        end
        check_eq("t2_end_busy", 32'(busy), 32'd0);

`ifndef PSG_BUS_ARB_PRIORITY_EN
        // ---- test 3: all valid, six writes, fair rotation every 4 cycles ----
        req_valid = 3'b111; req_we = 3'b111;
        req_addr  = {4'd2, 4'd1, 4'd0};
        req_data  = {8'h22, 8'h11, 8'h00};
        n = 0; last_cyc = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            #1;
            rec = 1'b0;
            if (req_ready != 3'b000) begin
                rec = 1'b1;
                idx = onehot_idx(req_ready);
                check_eq("t3_ready_idx", 32'(idx), 32'(n % 3));
                if (n > 0) begin
                    check_eq("t3_spacing", 32'(cyc - last_cyc), 32'd4);
                end
                last_cyc = cyc;
            end
            tick();
            if (rec) begin
                check_eq("t3_grant_id", 32'(grant_id), 32'(n % 3));
                check_eq("t3_addr",     32'(psg_addr), 32'(n % 3));
                n++;
            end
            if (n == 6) break;
        end
        check_eq("t3_count", 32'(n), 32'd6);
        req_valid = '0;
        repeat (4) tick();
`endif

        // ---- test 4: reset during the first WRITE cycle ----
        req_valid = 3'b001; req_we = 3'b001;
        req_addr[3:0] = 4'd5; req_data[7:0] = 8'h55;
        #1;
        check_eq("t4_ready", 32'(req_ready), 32'b001);
        tick();
        req_valid = '0;
        check_eq("t4_pre_wr_n", 32'(psg_wr_n), 32'd0);
        check_eq("t4_pre_addr", 32'(psg_addr), 32'd5);
        #2 reset = 1'b1;
        #1;
        check_eq("t4_wr_n",  32'(psg_wr_n),  32'd1);
        check_eq("t4_busy",  32'(busy),      32'd0);
        check_eq("t4_addr",  32'(psg_addr),  32'd0);
        check_eq("t4_data",  32'(psg_data),  32'd0);
        check_eq("t4_grant", 32'(grant_id),  32'd0);
        check_eq("t4_ready", 32'(req_ready), 32'd0);
        #2 reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq("t4_post_rsp",  32'(rsp_valid), 32'd0);
            check_eq("t4_post_wr_n", 32'(psg_wr_n),  32'd1);
        end

        // ---- test 5: req 0 withdraws before grant, req 1 is served ----
        req_valid = 3'b100; req_we = 3'b100;
        req_addr[11:8] = 4'hC; req_data[23:16] = 8'h22;
        #1;
        check_eq("t5_ready_r2", 32'(req_ready), 32'b100);
        tick();
        req_valid = 3'b011; req_we = 3'b011;
        req_addr[3:0] = 4'd3; req_addr[7:4] = 4'd9; req_data[15:8] = 8'h99;
        #1;
        check_eq("t5_ready_busy", 32'(req_ready), 32'd0);
        tick();
        tick();
        req_valid[0] = 1'b0;
        #1;
        check_eq("t5_ready_gap", 32'(req_ready), 32'd0);
        tick();
        check_eq("t5_ready_r1", 32'(req_ready), 32'b010);
        tick();
        req_valid = '0;
        check_eq("t5_grant", 32'(grant_id), 32'd1);
        check_eq("t5_addr1", 32'(psg_addr), 32'd9);
        check_eq("t5_data",  32'(psg_data), 32'h99);
        check_eq("t5_wr_n1", 32'(psg_wr_n), 32'd0);
        tick();
        check_eq("t5_addr2", 32'(psg_addr), 32'd9);
        check_eq("t5_wr_n2", 32'(psg_wr_n), 32'd0);
        tick();
        check_eq("t5_wr_n3", 32'(psg_wr_n), 32'd1);
        tick();
        check_eq("t5_idle",  32'(busy),     32'd0);

`ifdef PSG_BUS_ARB_PRIORITY_EN
        // ---- test 6: requester 0 wins over requester 2 while valid ----
        req_valid = 3'b101; req_we = 3'b101;
        req_addr[3:0] = 4'd1; req_addr[11:8] = 4'd2;
        n = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            #1;
            rec = 1'b0;
            if (req_ready != 3'b000) begin
                rec = 1'b1;
                idx = onehot_idx(req_ready);
                check_eq("t6_ready_idx", 32'(idx), (n < 2) ? 32'd0 : 32'd2);
            end
            tick();
            if (rec) begin
                check_eq("t6_grant_id", 32'(grant_id), (n < 2) ? 32'd0 : 32'd2);
                n++;
                if (n == 2) req_valid[0] = 1'b0;
            end
            if (n == 3) break;
        end
        check_eq("t6_count", 32'(n), 32'd3);
        req_valid = '0;
        repeat (4) tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
